// File: rtl/decode_queue_m1_if.sv
// Micro-op type package and the fetch/issue bundle of the M1 decode queue.
// The package sits here so it is compiled ahead of the interface that uses it.
package Types_m1;
    typedef struct packed {
        logic       call_alu;
        logic       call_bru;
        logic       call_lsu;
        logic       call_misc;
        logic       is_fence;
        logic       mem_store;
        logic [3:0] opcode;
        logic [3:0] func4;
    } uop_t;
endpackage

interface decode_queue_m1_if #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAYLOAD_W = 24
);
    import Types_m1::*;

    logic                                push_valid_in;
    logic                                push_ready_out;
    logic [3:0]                          push_opcode_in;
    logic [3:0]                          push_func4_in;
    logic [PAYLOAD_W-1:0]                push_payload_in;
    logic [LANES-1:0]                    issue_valid_out;
    logic                                issue_ready_in;
    uop_t [LANES-1:0]                    uop_out;
    logic [LANES-1:0][PAYLOAD_W-1:0]     payload_out;
    logic [LANES-1:0]                    illegal_out;
    logic                                fence_pending_out;
    logic                                fence_done_in;
    logic [$clog2(DEPTH+1)-1:0]          count_out;

    modport slave (
        input  push_valid_in, push_opcode_in, push_func4_in, push_payload_in,
        input  issue_ready_in, fence_done_in,
        output push_ready_out, issue_valid_out, uop_out, payload_out,
        output illegal_out, fence_pending_out, count_out
    );

    modport master (
        output push_valid_in, push_opcode_in, push_func4_in, push_payload_in,
        output issue_ready_in, fence_done_in,
        input  push_ready_out, issue_valid_out, uop_out, payload_out,
        input  illegal_out, fence_pending_out, count_out
    );
endinterface

// File: rtl/decode_queue_m1.sv
// Circular instruction queue with multi-lane M1 decode; groups end before
// fences/illegals and issue stalls in FENCE_WAIT until the memory system reports done.
module decode_queue_m1 #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAYLOAD_W = 24
) (
    input logic             clk_in,
    input logic             rst_in,
    input logic             flush_in,
    decode_queue_m1_if.slave bus
);
    import Types_m1::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef enum logic {RUN, FENCE_WAIT} state_e;

    logic [3:0]           op_q [DEPTH];
    logic [3:0]           f4_q [DEPTH];
    logic [PAYLOAD_W-1:0] pl_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, pop_cnt;
    state_e           state_q, state_d;

    logic [PTR_W-1:0]     lane_idx [LANES];
    logic [3:0]           lane_op  [LANES];
    logic [3:0]           lane_f4  [LANES];
    logic [LANES-1:0]     special, is_fence, is_illegal, valid;
    logic                 push, pop, fence_pop;

    function automatic uop_t decode(input logic [3:0] op, input logic [3:0] f4);
        uop_t u;
        u        = '0;
        u.opcode = op;
        u.func4  = f4;
        if (op <= 4'h6) begin
            u.call_alu = 1'b1;
        end else if (op <= 4'h9) begin
            u.call_bru = 1'b1;
        end else if (op == 4'hA) begin
            u.call_lsu  = 1'b1;
            u.mem_store = f4[0];
        end else if (op == 4'hB) begin
            u.call_misc = 1'b1;
            u.is_fence  = (f4 == 4'h0);
        end else begin
            u = '0;
        end
        return u;
    endfunction

    always_comb begin
        valid   = '0;
        pop_cnt = '0;
        bus.uop_out     = '0;
        bus.payload_out = '0;
        bus.illegal_out = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_idx[i]   = head_q + PTR_W'(i);
            lane_op[i]    = op_q[lane_idx[i]];
            lane_f4[i]    = f4_q[lane_idx[i]];
            is_illegal[i] = (lane_op[i] >= 4'hC);
            is_fence[i]   = (lane_op[i] == 4'hB) && (lane_f4[i] == 4'h0);
            special[i]    = is_illegal[i] || is_fence[i];
        end
        // A special head entry issues alone; a special later entry closes the group before it.
        valid[0] = (state_q == RUN) && (count_q != '0);
        for (int unsigned i = 1; i < LANES; i++) begin
            valid[i] = valid[i-1] && (CNT_W'(i) < count_q) && !special[i] && !special[0];
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            pop_cnt = pop_cnt + CNT_W'(valid[i]);
            if (valid[i]) begin
                bus.uop_out[i]     = decode(lane_op[i], lane_f4[i]);
                bus.payload_out[i] = pl_q[lane_idx[i]];
                bus.illegal_out[i] = is_illegal[i];
            end
        end
    end

    assign push      = bus.push_valid_in && bus.push_ready_out && !flush_in && !rst_in;
    assign pop       = valid[0] && bus.issue_ready_in;
    assign fence_pop = pop && is_fence[0];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (pop) begin
            head_d = head_q + PTR_W'(pop_cnt);
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - (pop ? pop_cnt : '0);
        case (state_q)
            RUN:        if (fence_pop)         state_d = FENCE_WAIT;
            FENCE_WAIT: if (bus.fence_done_in) state_d = RUN;
            default:                           state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            op_q[tail_q] <= bus.push_opcode_in;
            f4_q[tail_q] <= bus.push_func4_in;
            pl_q[tail_q] <= bus.push_payload_in;
        end
    end

    assign bus.issue_valid_out   = valid;
    assign bus.push_ready_out    = (count_q < CNT_W'(DEPTH));
    assign bus.fence_pending_out = (state_q == FENCE_WAIT);
    assign bus.count_out         = count_q;
endmodule
